// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REQ_IC = 2'd0,
    REQ_LD = 2'd1,
    REQ_ST = 2'd2
  } req_id_e;

  // Width codes are "byte count minus one".
  localparam logic [2:0] W_BYTE = 3'd0;
  localparam logic [2:0] W_HALF = 3'd1;
  localparam logic [2:0] W_WORD = 3'd3;

  localparam logic [31:0] UART_DATA_ADDR = 32'h0003_0000;
  localparam logic [31:0] UART_STAT_ADDR = 32'h0003_0004;

  // Mask selecting the low bytes that a read of the given width returns.
  function automatic logic [31:0] width_mask(input logic [2:0] w);
    logic [31:0] m;
    case (w)
      W_BYTE:  m = 32'h0000_00FF;
      W_HALF:  m = 32'h0000_FFFF;
      3'd2:    m = 32'h00FF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: search starts just after last_i.
module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic    [2:0] eligible_i,  // bit0 IC, bit1 LD, bit2 ST
  input  req_id_e       last_i,
  output logic          valid_o,
  output req_id_e       id_o
);

  // Rotate priority so the most recently granted requester is checked last.
  always_comb begin
    valid_o = |eligible_i;
    id_o    = REQ_IC;
    case (last_i)
      REQ_IC: begin
        if      (eligible_i[1]) id_o = REQ_LD;
        else if (eligible_i[2]) id_o = REQ_ST;
        else if (eligible_i[0]) id_o = REQ_IC;
      end
      REQ_LD: begin
        if      (eligible_i[2]) id_o = REQ_ST;
        else if (eligible_i[0]) id_o = REQ_IC;
        else if (eligible_i[1]) id_o = REQ_LD;
      end
      default: begin
        if      (eligible_i[0]) id_o = REQ_IC;
        else if (eligible_i[1]) id_o = REQ_LD;
        else if (eligible_i[2]) id_o = REQ_ST;
      end
    endcase
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin front end that funnels ICache fills, loads and stores onto the
// single memory-controller port. ICache fills run as two word reads.
//
// Handshake: every requester raises its _en as a level and holds all fields
// stable until it sees its own 1-cycle done pulse, then drops _en on the next
// edge. Towards the controller ARMC_en is a level held with stable fields
// until the matching MCAR_r_en / MCAR_w_en pulse arrives.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] UART_ADDR0 = ADDR_WIDTH'(mem_arb_pkg::UART_DATA_ADDR),
  parameter logic [ADDR_WIDTH-1:0] UART_ADDR1 = ADDR_WIDTH'(mem_arb_pkg::UART_STAT_ADDR)
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst_n,
  input  logic                  Sys_rdy,
  input  logic                  io_buffer_full,
  input  logic                  ICAR_en,
  input  logic [ADDR_WIDTH-1:0] ICAR_addr,
  output logic                  ARIC_en,
  output logic [63:0]           ARIC_block,
  input  logic                  LDAR_en,
  input  logic [2:0]            LDAR_width,
  input  logic [ADDR_WIDTH-1:0] LDAR_addr,
  output logic                  ARLD_en,
  output logic [31:0]           ARLD_data,
  input  logic                  STAR_en,
  input  logic [2:0]            STAR_width,
  input  logic [ADDR_WIDTH-1:0] STAR_addr,
  input  logic [31:0]           STAR_data,
  output logic                  ARST_en,
  output logic                  ARMC_en,
  output logic                  ARMC_wr,
  output logic [2:0]            ARMC_width,
  output logic [ADDR_WIDTH-1:0] ARMC_addr,
  output logic [31:0]           ARMC_data,
  input  logic                  MCAR_r_en,
  input  logic                  MCAR_w_en,
  input  logic [31:0]           MCAR_data,
  output logic [1:0]            dbg_state_o
);

  state_e                state_q;
  req_id_e               grant_q;
  req_id_e               last_q;
  logic                  idx_q;
  logic [63:0]           block_q;
  logic                  aric_en_q;
  logic                  arld_en_q;
  logic [31:0]           arld_data_q;
  logic                  arst_en_q;
  logic                  armc_en_q;
  logic                  armc_wr_q;
  logic [2:0]            armc_width_q;
  logic [ADDR_WIDTH-1:0] armc_addr_q;
  logic [31:0]           armc_data_q;

  logic                  st_uart;
  logic [2:0]            eligible;
  logic                  pick_valid;
  req_id_e               pick_id;
  logic                  mc_done_d;

  // A UART store waits while the UART buffer is full; everything else is eligible as raised.
  assign st_uart   = (STAR_addr == UART_ADDR0) || (STAR_addr == UART_ADDR1);
  assign eligible  = {STAR_en && !(io_buffer_full && st_uart), LDAR_en, ICAR_en};
  // Only the done pulse matching the outstanding direction completes a transaction.
  assign mc_done_d = armc_wr_q ? MCAR_w_en : MCAR_r_en;

  rr_pick3 u_pick (
    .eligible_i (eligible),
    .last_i     (last_q),
    .valid_o    (pick_valid),
    .id_o       (pick_id)
  );

  // Main FSM: arbitrate in IDLE, wait for controller done in BUSY, one idle cycle in GAP.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      state_q      <= IDLE;
      grant_q      <= REQ_IC;
      last_q       <= REQ_ST;
      idx_q        <= 1'b0;
      block_q      <= '0;
      aric_en_q    <= 1'b0;
      arld_en_q    <= 1'b0;
      arld_data_q  <= '0;
      arst_en_q    <= 1'b0;
      armc_en_q    <= 1'b0;
      armc_wr_q    <= 1'b0;
      armc_width_q <= '0;
      armc_addr_q  <= '0;
      armc_data_q  <= '0;
    end else if (Sys_rdy) begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q   <= BUSY;
            grant_q   <= pick_id;
            last_q    <= pick_id;
            idx_q     <= 1'b0;
            armc_en_q <= 1'b1;
            case (pick_id)
              REQ_IC: begin
                armc_wr_q    <= 1'b0;
                armc_width_q <= W_WORD;
                armc_addr_q  <= ICAR_addr;
                armc_data_q  <= '0;
              end
              REQ_LD: begin
                armc_wr_q    <= 1'b0;
                armc_width_q <= LDAR_width;
                armc_addr_q  <= LDAR_addr;
                armc_data_q  <= '0;
              end
              default: begin
                armc_wr_q    <= 1'b1;
                armc_width_q <= STAR_width;
                armc_addr_q  <= STAR_addr;
                armc_data_q  <= STAR_data;
              end
            endcase
          end
        end
        BUSY: begin
          if (mc_done_d) begin
            armc_en_q <= 1'b0;
            state_q   <= GAP;
            case (grant_q)
              REQ_IC: begin
                if (!idx_q) begin
                  block_q[31:0] <= MCAR_data;
                  idx_q         <= 1'b1;
                end else begin
                  block_q[63:32] <= MCAR_data;
                  aric_en_q      <= 1'b1;
                end
              end
              REQ_LD: begin
                arld_data_q <= MCAR_data & width_mask(armc_width_q);
                arld_en_q   <= 1'b1;
              end
              default: arst_en_q <= 1'b1;
            endcase
          end
        end
        GAP: begin
          aric_en_q <= 1'b0;
          arld_en_q <= 1'b0;
          arst_en_q <= 1'b0;
          if (grant_q == REQ_IC && idx_q && !aric_en_q) begin
            // Second half of the block: same requester, next word.
            armc_en_q   <= 1'b1;
            armc_addr_q <= ICAR_addr + ADDR_WIDTH'(4);
            state_q     <= BUSY;
          end else begin
            idx_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ARIC_en     = aric_en_q;
  assign ARIC_block  = block_q;
  assign ARLD_en     = arld_en_q;
  assign ARLD_data   = arld_data_q;
  assign ARST_en     = arst_en_q;
  assign ARMC_en     = armc_en_q;
  assign ARMC_wr     = armc_wr_q;
  assign ARMC_width  = armc_width_q;
  assign ARMC_addr   = armc_addr_q;
  assign ARMC_data   = armc_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: vector table plus directed sequences.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sys_rdy;
  logic        io_full;
  logic        ic_en;
  logic [31:0] ic_addr;
  logic        aric_en;
  logic [63:0] aric_block;
  logic        ld_en;
  logic [2:0]  ld_width;
  logic [31:0] ld_addr;
  logic        arld_en;
  logic [31:0] arld_data;
  logic        st_en;
  logic [2:0]  st_width;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        arst_en;
  logic        armc_en;
  logic        armc_wr;
  logic [2:0]  armc_width;
  logic [31:0] armc_addr;
  logic [31:0] armc_data;
  logic        mc_r;
  logic        mc_w;
  logic [31:0] mc_data;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] IC_A = 32'h400;
  localparam logic [31:0] LD_A = 32'h500;
  localparam logic [31:0] ST_A = 32'h600;

  mem_req_arbiter #(.ADDR_WIDTH(32)) dut (
    .Sys_clk        (clk),
    .Sys_rst_n      (rst_n),
    .Sys_rdy        (sys_rdy),
    .io_buffer_full (io_full),
    .ICAR_en        (ic_en),
    .ICAR_addr      (ic_addr),
    .ARIC_en        (aric_en),
    .ARIC_block     (aric_block),
    .LDAR_en        (ld_en),
    .LDAR_width     (ld_width),
    .LDAR_addr      (ld_addr),
    .ARLD_en        (arld_en),
    .ARLD_data      (arld_data),
    .STAR_en        (st_en),
    .STAR_width     (st_width),
    .STAR_addr      (st_addr),
    .STAR_data      (st_data),
    .ARST_en        (arst_en),
    .ARMC_en        (armc_en),
    .ARMC_wr        (armc_wr),
    .ARMC_width     (armc_width),
    .ARMC_addr      (armc_addr),
    .ARMC_data      (armc_data),
    .MCAR_r_en      (mc_r),
    .MCAR_w_en      (mc_w),
    .MCAR_data      (mc_data),
    .dbg_state_o    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Controller model: wait, then one-cycle done pulse with data.
  task automatic mc_respond(input bit wr, input logic [31:0] d, input int delay);
    repeat (delay) tick();
    if (wr) mc_w = 1'b1;
    else    mc_r = 1'b1;
    mc_data = d;
    tick();
    mc_r = 1'b0;
    mc_w = 1'b0;
  endtask

  // Bounded wait for a new controller request.
  task automatic wait_armc(input string name);
    int n = 0;
    while (!armc_en && n < 8) begin
      tick();
      n++;
    end
    check({name, "_grant_timeout"}, armc_en, 1'b1);
  endtask

  // Serve whatever is granted; check it is the expected requester.
  task automatic serve_grant(input logic [31:0] exp_addr, input string name);
    wait_armc(name);
    check({name, "_addr"}, armc_addr, exp_addr);
    case (armc_addr)
      IC_A: begin
        mc_respond(1'b0, 32'h0000_0001, 1);
        tick();
        check({name, "_ic_word1_addr"}, armc_addr, IC_A + 32'd4);
        mc_respond(1'b0, 32'h0000_0002, 1);
        check({name, "_ic_done"}, aric_en, 1'b1);
        ic_en = 1'b0;
      end
      LD_A, 32'h800: begin
        mc_respond(1'b0, 32'h1234_5678, 1);
        check({name, "_ld_done"}, arld_en, 1'b1);
        ld_en = 1'b0;
      end
      ST_A: begin
        mc_respond(1'b1, 32'h0, 1);
        check({name, "_st_done"}, arst_en, 1'b1);
        st_en = 1'b0;
      end
      default: mc_respond(armc_wr, 32'h0, 1);
    endcase
  endtask

  typedef struct {
    bit          st;
    bit          full;
    logic [2:0]  w;
    logic [31:0] addr;
    logic [31:0] d;       // store data, or controller read data
    logic [31:0] exp_ld;  // expected ARLD_data for loads
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{st: 1'b0, full: 1'b0, w: 3'd0, addr: 32'h104,   d: 32'hAABB_CC5A, exp_ld: 32'h0000_005A};
    vecs[1] = '{st: 1'b0, full: 1'b0, w: 3'd1, addr: 32'h2002,  d: 32'h8765_4321, exp_ld: 32'h0000_4321};
    vecs[2] = '{st: 1'b0, full: 1'b0, w: 3'd3, addr: 32'h3000,  d: 32'hCAFE_F00D, exp_ld: 32'hCAFE_F00D};
    vecs[3] = '{st: 1'b1, full: 1'b0, w: 3'd0, addr: 32'h10,    d: 32'h0000_00AB, exp_ld: 32'h0};
    vecs[4] = '{st: 1'b1, full: 1'b0, w: 3'd3, addr: 32'h30004, d: 32'h1234_5678, exp_ld: 32'h0};
    vecs[5] = '{st: 1'b1, full: 1'b1, w: 3'd1, addr: 32'h20,    d: 32'h0000_BEEF, exp_ld: 32'h0};

    rst_n = 1'b0; sys_rdy = 1'b1; io_full = 1'b0;
    ic_en = 1'b0; ic_addr = '0;
    ld_en = 1'b0; ld_width = '0; ld_addr = '0;
    st_en = 1'b0; st_width = '0; st_addr = '0; st_data = '0;
    mc_r = 1'b0; mc_w = 1'b0; mc_data = '0;
    repeat (2) tick();

    // Reset state
    check("rst_armc_en", armc_en, 1'b0);
    check("rst_aric_en", aric_en, 1'b0);
    check("rst_aric_block", aric_block, 64'h0);
    check("rst_arld_en", arld_en, 1'b0);
    check("rst_arld_data", arld_data, 32'h0);
    check("rst_arst_en", arst_en, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    tick();

    // Single load/store transactions from the table
    for (int i = 0; i < 6; i++) begin
      io_full = vecs[i].full;
      if (vecs[i].st) begin
        st_en = 1'b1; st_width = vecs[i].w; st_addr = vecs[i].addr; st_data = vecs[i].d;
      end else begin
        ld_en = 1'b1; ld_width = vecs[i].w; ld_addr = vecs[i].addr;
      end
      tick();
      check($sformatf("v%0d_armc_en", i), armc_en, 1'b1);
      check($sformatf("v%0d_addr", i), armc_addr, vecs[i].addr);
      check($sformatf("v%0d_width", i), armc_width, vecs[i].w);
      check($sformatf("v%0d_wr", i), armc_wr, vecs[i].st);
      if (vecs[i].st) check($sformatf("v%0d_wdata", i), armc_data, vecs[i].d);
      if (i == 0) begin
        // A write-done while a read is outstanding is ignored.
        mc_w = 1'b1;
        tick();
        mc_w = 1'b0;
        check("v0_wrong_done_ld", arld_en, 1'b0);
        check("v0_wrong_done_held", armc_en, 1'b1);
      end
      mc_respond(vecs[i].st, vecs[i].d, 2);
      if (vecs[i].st) begin
        check($sformatf("v%0d_arst_en", i), arst_en, 1'b1);
      end else begin
        check($sformatf("v%0d_arld_en", i), arld_en, 1'b1);
        check($sformatf("v%0d_arld_data", i), arld_data, vecs[i].exp_ld);
      end
      check($sformatf("v%0d_gap_state", i), dbg_state, 2'd2);
      check($sformatf("v%0d_en_low0", i), armc_en, 1'b0);
      ld_en = 1'b0; st_en = 1'b0;
      tick();
      check($sformatf("v%0d_pulse_end", i), arld_en | arst_en, 1'b0);
      check($sformatf("v%0d_en_low1", i), armc_en, 1'b0);
      tick();
      check($sformatf("v%0d_en_low2", i), armc_en, 1'b0);
    end
    io_full = 1'b0;

    // ICache fill: two reads with a GAP between
    ic_en = 1'b1; ic_addr = 32'h200;
    tick();
    check("ic_w0_en", armc_en, 1'b1);
    check("ic_w0_addr", armc_addr, 32'h200);
    check("ic_w0_width", armc_width, 3'd3);
    check("ic_w0_wr", armc_wr, 1'b0);
    mc_respond(1'b0, 32'h1122_3344, 1);
    check("ic_w0_no_done", aric_en, 1'b0);
    check("ic_gap_en", armc_en, 1'b0);
    tick();
    check("ic_w1_en", armc_en, 1'b1);
    check("ic_w1_addr", armc_addr, 32'h204);
    mc_respond(1'b0, 32'h5566_7788, 2);
    check("ic_done", aric_en, 1'b1);
    check("ic_block", aric_block, 64'h5566_7788_1122_3344);
    ic_en = 1'b0;
    tick();
    check("ic_done_pulse_end", aric_en, 1'b0);
    tick();
    check("ic_no_regrant", armc_en, 1'b0);

    // Simultaneous requests from reset: IC, LD, ST, then the same again
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ic_addr = IC_A; ld_addr = LD_A; ld_width = 3'd3;
    st_addr = ST_A; st_width = 3'd3; st_data = 32'h99;
    for (int r = 0; r < 2; r++) begin
      ic_en = 1'b1; ld_en = 1'b1; st_en = 1'b1;
      serve_grant(IC_A, $sformatf("rr%0d_1st", r));
      serve_grant(LD_A, $sformatf("rr%0d_2nd", r));
      serve_grant(ST_A, $sformatf("rr%0d_3rd", r));
    end

    // UART store held while full; load goes ahead
    io_full = 1'b1;
    st_en = 1'b1; st_addr = 32'h30000; st_width = 3'd0; st_data = 32'h77;
    ld_en = 1'b1; ld_addr = 32'h800; ld_width = 3'd3;
    serve_grant(32'h800, "uart_ld_first");
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("uart_held%0d", k), armc_en, 1'b0);
    end
    io_full = 1'b0;
    tick();
    check("uart_st_en", armc_en, 1'b1);
    check("uart_st_addr", armc_addr, 32'h30000);
    check("uart_st_wr", armc_wr, 1'b1);
    check("uart_st_data", armc_data, 32'h77);
    io_full = 1'b1;  // ignored once granted
    mc_respond(1'b1, 32'h0, 2);
    check("uart_st_done", arst_en, 1'b1);
    st_en = 1'b0; io_full = 1'b0;
    tick();
    check("uart_st_pulse_end", arst_en, 1'b0);

    // Reset during the second ICache word
    ic_en = 1'b1; ic_addr = 32'h200;
    wait_armc("rst_mid_w0");
    mc_respond(1'b0, 32'hAAAA_0000, 1);
    tick();
    check("rst_mid_w1_addr", armc_addr, 32'h204);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_armc_en", armc_en, 1'b0);
    check("rst_mid_armc_addr", armc_addr, 32'h0);
    check("rst_mid_block", aric_block, 64'h0);
    check("rst_mid_arld_data", arld_data, 32'h0);
    check("rst_mid_state", dbg_state, 2'd0);
    ic_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst_mid_no_done%0d", k), aric_en | armc_en, 1'b0);
    end
    ic_en = 1'b1; ic_addr = 32'h300;
    tick();
    check("fresh_w0_addr", armc_addr, 32'h300);
    mc_respond(1'b0, 32'h0102_0304, 1);
    tick();
    check("fresh_w1_addr", armc_addr, 32'h304);
    mc_respond(1'b0, 32'h0A0B_0C0D, 1);
    check("fresh_done", aric_en, 1'b1);
    check("fresh_block", aric_block, 64'h0A0B_0C0D_0102_0304);
    ic_en = 1'b0;
    tick();

    // Sys_rdy low freezes a BUSY load with the done pulse already present
    ld_en = 1'b1; ld_addr = 32'h900; ld_width = 3'd1;
    tick();
    check("rdy_ld_en", armc_en, 1'b1);
    sys_rdy = 1'b0; mc_r = 1'b1; mc_data = 32'hBEEF_1234;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rdy_frozen_en%0d", k), armc_en, 1'b1);
      check($sformatf("rdy_frozen_done%0d", k), arld_en, 1'b0);
      check($sformatf("rdy_frozen_state%0d", k), dbg_state, 2'd1);
    end
    sys_rdy = 1'b1;
    tick();
    check("rdy_ld_done", arld_en, 1'b1);
    check("rdy_ld_data", arld_data, 32'h0000_1234);
    mc_r = 1'b0; ld_en = 1'b0; sys_rdy = 1'b0;
    tick();
    check("rdy_pulse_stretch", arld_en, 1'b1);
    sys_rdy = 1'b1;
    tick();
    check("rdy_pulse_end", arld_en, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
